ram_word_loader: RTL and testbench
==================================

Name: ram_word_loader

Overview:
- Upstream feeder for the dual-port synchronous RAM model. It drives port A (address_a, wren_a, data_a) during bulk initialisation.
- Accepts a byte stream through a valid/ready handshake and assembles the bytes little-endian into WIDTH-bit words.
- Writes each word to consecutive RAM addresses starting at a base address, then reports completion.
- Used to load program and heap images at run time instead of relying on an init file.

Parameters:
- WIDTH, 28, RAM word width; must match the RAM's width_a.
- WIDTHAD, 12, RAM address width; must match the RAM's widthad_a.
- NBYTES, (WIDTH+7)/8, bytes per word; derived, never overridden.

Ports:
- clock0  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base  in  WIDTHAD  first RAM word address; sampled when start is accepted.
- count  in  WIDTHAD+1  number of words to load; sampled when start is accepted.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- address_a  out  WIDTHAD  RAM port-A address.
- wren_a  out  1  RAM port-A write enable.
- data_a  out  WIDTH  RAM port-A write data.
- busy  out  1  load in progress.
- done  out  1  load complete; held high until the next accepted start.
- checksum  out  WIDTH  XOR of all words written (see Optional Feature).

Behaviour:
- Interface: one clock (clock0); reset is synchronous and active-high. All outputs are registered, except in_ready, which is decoded from the state.
- Reset values: state IDLE; in_ready 0, wren_a 0, address_a 0, data_a 0, busy 0, done 0, checksum 0.
- States:
  - IDLE: waiting for start.
  - FILL: collecting bytes.
  - WRITE: issuing the RAM write.
  - DONE: load finished.
- IDLE:
  - start=1 with count!=0 latches base and count, clears the byte index, word index and checksum, sets busy=1, clears done, and moves to FILL.
  - start=1 with count==0 moves directly to DONE with zero writes; busy stays 0.
- FILL:
  - in_ready=1. A byte is accepted when in_valid && in_ready. Byte k (k=0..NBYTES-1) fills bits [8k+7:8k].
  - Bits of the last byte above WIDTH-1 are discarded.
  - When the byte with k=NBYTES-1 is accepted, the next cycle is WRITE.
- WRITE (exactly one cycle):
  - wren_a=1, address_a=(base+word_index) mod 2^WIDTHAD, data_a = the assembled word. in_ready=0.
  - The RAM captures the write on the edge ending this cycle.
  - word_index then increments. If it now equals count, go to DONE; otherwise go back to FILL.
- DONE: busy=0, done=1, wren_a=0, in_ready=0. start=1 behaves as in IDLE (starts a new load).
- wren_a is high only in WRITE. address_a and data_a hold their last values outside WRITE.
- Throughput: NBYTES+1 cycles per word when in_valid is held high.
- Address wrap-around: base+index wraps modulo 2^WIDTHAD. A count of 2^WIDTHAD fills the whole RAM; count above 2^WIDTHAD is undefined.
- start while busy (FILL or WRITE) is ignored.
- Reset mid-load: return to IDLE and discard the partial word. RAM words already written are unaffected, and no further write is issued.
- Bytes presented while in_ready=0 are not consumed; the source must hold them.

Optional Feature:
- Macro: RAM_WORD_LOADER_CHECKSUM_EN.
- Defined: checksum is XOR-accumulated with data_a in every WRITE cycle. It is cleared when a start is accepted, stays valid while done=1, and resets to 0.
- Undefined: checksum is tied to 0 and no accumulator register is built. All other behaviour is identical.

Test Plan:
- Basic load, WIDTH=28: start with base=0x010, count=2; stream 78 56 34 12 EF CD AB 89 with in_valid held high.
  - Write 0x2345678 to 0x010 and 0x9ABCDEF to 0x011.
  - The two wren_a pulses are 5 cycles apart.
  - done=1 on the cycle after the second write; checksum=0xB9F9B97 with the macro, 0 without.
- Wrap-around: base=0xFFF, count=2 -> writes land at 0xFFF, then 0x000.
- Stall: drop in_valid for 3 cycles mid-word.
  - No bytes are consumed and wren_a stays low.
  - The word completes correctly once valid resumes.
- Zero count: start with count=0 -> the next cycle has done=1, busy stays 0, and wren_a never asserts.
- Reset mid-load: assert reset after 2 bytes of the second word.
  - All outputs return to reset values and no second write occurs.
  - A new start loads correctly from byte 0.
- start pulsed during FILL is ignored: the original base and count complete unchanged.

Source files
------------

// File: rtl/ram_word_loader_if.sv
// ram_word_loader_if: control, byte-stream and RAM port-A signals of the
// word loader. The slave modport is the loader's view; the master modport is
// the view of whatever drives the loader and observes the RAM port.
interface ram_word_loader_if #(
    parameter int WIDTH   = 28,
    parameter int WIDTHAD = 12
);
    logic               start;
    logic [WIDTHAD-1:0] base;
    logic [WIDTHAD:0]   count;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTHAD-1:0] address_a;
    logic               wren_a;
    logic [WIDTH-1:0]   data_a;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   checksum;

    modport master (
        output start, base, count, in_data, in_valid,
        input  in_ready, address_a, wren_a, data_a, busy, done, checksum
    );

    modport slave (
        input  start, base, count, in_data, in_valid,
        output in_ready, address_a, wren_a, data_a, busy, done, checksum
    );
endinterface

// File: rtl/ram_word_loader.sv
// ram_word_loader: assembles a little-endian byte stream into WIDTH-bit words
// and writes them to consecutive RAM port-A addresses starting at base.
// Optional feature macro: RAM_WORD_LOADER_CHECKSUM_EN (XOR checksum of all
// written words); when undefined checksum is tied to zero.
module ram_word_loader #(
    parameter int WIDTH   = 28,
    parameter int WIDTHAD = 12
) (
    input logic              clock0,
    input logic              reset,
    ram_word_loader_if.slave bus
);
    localparam int NBYTES = (WIDTH + 7) / 8;
    localparam int BIDXW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t               state;
    state_t               next_state;
    logic [WIDTHAD-1:0]   base_q;
    logic [WIDTHAD:0]     count_q;
    logic [WIDTHAD:0]     word_idx;
    logic [BIDXW-1:0]     byte_idx;
    logic [NBYTES*8-1:0]  word_buf;
    logic [NBYTES*8-1:0]  word_next;
    logic                 accept;
    logic                 last_byte;
    logic                 last_word;
    logic                 start_ok;

    // in_ready is the only output decoded straight from the state
    assign bus.in_ready = (state == FILL);

    // Handshake decode and byte insertion into the word being assembled
    always_comb begin
        accept    = bus.in_valid && (state == FILL);
        last_byte = (byte_idx == BIDXW'(NBYTES - 1));
        last_word = ((word_idx + 1'b1) == count_q);
        start_ok  = bus.start && ((state == IDLE) || (state == DONE));
        word_next = word_buf;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (accept && (byte_idx == BIDXW'(k))) begin
                word_next[8*k +: 8] = bus.in_data;
            end
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    next_state = (bus.count == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (accept && last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = last_word ? DONE : FILL;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock0) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs and datapath; outputs are loaded from next_state so
    // that wren_a/busy/done line up with the state they describe
    always_ff @(posedge clock0) begin
        if (reset) begin
            base_q        <= '0;
            count_q       <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            word_buf      <= '0;
            bus.address_a <= '0;
            bus.data_a    <= '0;
            bus.wren_a    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.wren_a <= (next_state == WRITE);
            bus.busy   <= (next_state == FILL) || (next_state == WRITE);
            bus.done   <= (next_state == DONE);
            if (start_ok) begin
                base_q   <= bus.base;
                count_q  <= bus.count;
                word_idx <= '0;
                byte_idx <= '0;
            end
            if (accept) begin
                word_buf <= word_next;
                byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
            end
            if ((state == FILL) && (next_state == WRITE)) begin
                bus.address_a <= base_q + word_idx[WIDTHAD-1:0];
                bus.data_a    <= word_next[WIDTH-1:0];
            end
            if (state == WRITE) begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

`ifdef RAM_WORD_LOADER_CHECKSUM_EN
    // XOR accumulator over every word presented on data_a during WRITE
    always_ff @(posedge clock0) begin
        if (reset) begin
            bus.checksum <= '0;
        end else if (start_ok) begin
            bus.checksum <= '0;
        end else if (state == WRITE) begin
            bus.checksum <= bus.checksum ^ bus.data_a;
        end
    end
`else
    assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_ram_word_loader.sv
// tb_ram_word_loader: randomized self-checking bench for ram_word_loader.
// Expected RAM writes come from an arithmetic model of the byte-to-word rules.
module tb_ram_word_loader;
    localparam int WIDTH   = 28;
    localparam int WIDTHAD = 12;
    localparam int NBYTES  = (WIDTH + 7) / 8;

    typedef logic [7:0]         u8_t;
    typedef u8_t                u8_q_t[$];
    typedef logic [WIDTHAD-1:0] addr_q_t[$];
    typedef logic [WIDTH-1:0]   data_q_t[$];
    typedef struct {
        logic [WIDTHAD-1:0] addr;
        logic [WIDTH-1:0]   data;
        int                 cyc;
    } wr_t;

    logic clock0 = 1'b0;
    logic reset  = 1'b1;
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    wr_t  wlog[$];

    ram_word_loader_if #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD)) bus ();

    ram_word_loader #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD)) dut (
        .clock0 (clock0),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clock0 = ~clock0;

    always @(posedge clock0) cyc <= cyc + 1;

    // Record every RAM write shortly after the edge that starts it
    always begin
        @(posedge clock0);
        #1;
        if (bus.wren_a === 1'b1) wlog.push_back('{bus.address_a, bus.data_a, cyc});
    end

    // Reference: word i is bytes[i*NBYTES .. +NBYTES-1], little-endian,
    // truncated to WIDTH bits, at address (base + i) mod 2^WIDTHAD
    function automatic void model(input logic [WIDTHAD-1:0] b, input int n,
                                  input u8_q_t bytes, output addr_q_t ea,
                                  output data_q_t ed);
        longint unsigned w;
        ea = {};
        ed = {};
        for (int i = 0; i < n; i++) begin
            w = 0;
            for (int k = 0; k < NBYTES; k++) w += longint'(bytes[i*NBYTES + k]) * (64'd1 << (8*k));
            w = w % (64'd1 << WIDTH);
            ea.push_back(WIDTHAD'((int'(b) + i) % (1 << WIDTHAD)));
            ed.push_back(WIDTH'(w));
        end
    endfunction

    function automatic logic [WIDTH-1:0] exp_checksum(input data_q_t ed);
        logic [WIDTH-1:0] x;
        x = '0;
`ifdef RAM_WORD_LOADER_CHECKSUM_EN
        foreach (ed[i]) x = x ^ ed[i];
`endif
        return x;
    endfunction

    function automatic u8_q_t rand_bytes(input int n);
        u8_q_t q;
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic pulse_start(input logic [WIDTHAD-1:0] b, input logic [WIDTHAD:0] c);
        @(negedge clock0);
        bus.start = 1'b1;
        bus.base  = b;
        bus.count = c;
        @(negedge clock0);
        bus.start = 1'b0;
    endtask

    // Presents bytes with random valid gaps; called and returns at a negedge
    task automatic stream(input u8_q_t bytes, input int unsigned gap_pct, output bit ok);
        int unsigned idx;
        int          guard;
        bit          acc;
        idx   = 0;
        guard = 0;
        ok    = 1'b1;
        while (idx < bytes.size()) begin
            if (guard > 1000) begin
                ok = 1'b0;
                break;
            end
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            bus.in_data  = bus.in_valid ? bytes[idx] : 8'($urandom);
            acc = bus.in_valid && (bus.in_ready === 1'b1);
            @(posedge clock0);
            if (acc) idx++;
            @(negedge clock0);
            guard++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock0);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        tests++; if (bus.wren_a !== 1'b0) begin fails++; $display("FAIL reset_wren got=%b exp=0", bus.wren_a); end
        tests++; if (bus.address_a !== '0) begin fails++; $display("FAIL reset_addr got=%h exp=0", bus.address_a); end
        tests++; if (bus.data_a !== '0) begin fails++; $display("FAIL reset_data got=%h exp=0", bus.data_a); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        tests++; if (bus.checksum !== '0) begin fails++; $display("FAIL reset_checksum got=%h exp=0", bus.checksum); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        u8_q_t   bytes;
        addr_q_t ea;
        data_q_t ed;
        int      n0;
        bit      ok;
        bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h89};
        n0 = wlog.size();
        pulse_start(12'h010, 13'd2);
        stream(bytes, 0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_stream_timeout got=0 exp=1"); end
        @(negedge clock0);
        tests++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL basic_done got=%b/%b exp=1/0", bus.done, bus.busy); end
        ea = '{12'h010, 12'h011};
        ed = '{28'h2345678, 28'h9ABCDEF};
        tests++; if (bus.checksum !== exp_checksum(ed)) begin fails++; $display("FAIL basic_checksum got=%h exp=%h", bus.checksum, exp_checksum(ed)); end
        tests++; if (wlog.size() - n0 != 2) begin fails++; $display("FAIL basic_nwrites got=%0d exp=2", wlog.size() - n0); end
        for (int i = 0; i < 2 && n0 + i < wlog.size(); i++) begin
            tests++;
            if (wlog[n0+i].addr !== ea[i] || wlog[n0+i].data !== ed[i]) begin
                fails++; $display("FAIL basic_write%0d got=%h:%h exp=%h:%h", i, wlog[n0+i].addr, wlog[n0+i].data, ea[i], ed[i]);
            end
        end
        if (wlog.size() >= n0 + 2) begin
            tests++;
            if (wlog[n0+1].cyc - wlog[n0].cyc != NBYTES + 1) begin
                fails++; $display("FAIL basic_spacing got=%0d exp=%0d", wlog[n0+1].cyc - wlog[n0].cyc, NBYTES + 1);
            end
        end
    endtask

    task automatic test_wrap;
        u8_q_t   bytes;
        addr_q_t ea;
        data_q_t ed;
        int      n0;
        bit      ok;
        bytes = rand_bytes(2 * NBYTES);
        model(12'hFFF, 2, bytes, ea, ed);
        n0 = wlog.size();
        pulse_start(12'hFFF, 13'd2);
        stream(bytes, 20, ok);
        wait_done(ok);
        tests++; if (!ok) begin fails++; $display("FAIL wrap_done_timeout got=0 exp=1"); end
        tests++; if (wlog.size() - n0 != 2) begin fails++; $display("FAIL wrap_nwrites got=%0d exp=2", wlog.size() - n0); end
        for (int i = 0; i < 2 && n0 + i < wlog.size(); i++) begin
            tests++;
            if (wlog[n0+i].addr !== ea[i] || wlog[n0+i].data !== ed[i]) begin
                fails++; $display("FAIL wrap_write%0d got=%h:%h exp=%h:%h", i, wlog[n0+i].addr, wlog[n0+i].data, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_stall;
        u8_q_t             bytes;
        addr_q_t           ea;
        data_q_t           ed;
        logic [WIDTHAD-1:0] b;
        int                n0;
        bit                ok;
        b     = WIDTHAD'($urandom);
        bytes = rand_bytes(NBYTES);
        model(b, 1, bytes, ea, ed);
        n0 = wlog.size();
        pulse_start(b, 13'd1);
        stream(bytes[0:1], 0, ok);
        bus.in_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.wren_a !== 1'b0 || bus.in_ready !== 1'b1) begin
                fails++; $display("FAIL stall_cycle%0d wren/ready got=%b/%b exp=0/1", i, bus.wren_a, bus.in_ready);
            end
            @(negedge clock0);
        end
        stream(bytes[2:NBYTES-1], 0, ok);
        wait_done(ok);
        tests++; if (!ok) begin fails++; $display("FAIL stall_done_timeout got=0 exp=1"); end
        tests++; if (wlog.size() - n0 != 1) begin fails++; $display("FAIL stall_nwrites got=%0d exp=1", wlog.size() - n0); end
        if (wlog.size() > n0) begin
            tests++;
            if (wlog[n0].addr !== ea[0] || wlog[n0].data !== ed[0]) begin
                fails++; $display("FAIL stall_write got=%h:%h exp=%h:%h", wlog[n0].addr, wlog[n0].data, ea[0], ed[0]);
            end
        end
    endtask

    task automatic test_zero_count;
        int n0;
        @(negedge clock0);
        reset = 1'b1;
        @(negedge clock0);
        reset = 1'b0;
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zero_pre_done got=%b exp=0", bus.done); end
        n0 = wlog.size();
        pulse_start(WIDTHAD'($urandom), 13'd0);
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL zero_done got=%b exp=1", bus.done); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.busy !== 1'b0 || bus.wren_a !== 1'b0) begin
                fails++; $display("FAIL zero_idle%0d busy/wren got=%b/%b exp=0/0", i, bus.busy, bus.wren_a);
            end
            @(negedge clock0);
        end
        tests++; if (wlog.size() != n0) begin fails++; $display("FAIL zero_nwrites got=%0d exp=0", wlog.size() - n0); end
    endtask

    task automatic test_reset_mid_load;
        u8_q_t             bytes;
        addr_q_t           ea;
        data_q_t           ed;
        logic [WIDTHAD-1:0] b;
        int                n0;
        bit                ok;
        b     = WIDTHAD'($urandom);
        bytes = rand_bytes(2 * NBYTES);
        bytes[0] = bytes[0] | 8'h01;
        model(b, 1, bytes, ea, ed);
        n0 = wlog.size();
        pulse_start(b, 13'd2);
        stream(bytes[0:NBYTES-1], 0, ok);
        stream(bytes[NBYTES:NBYTES+1], 0, ok);
        reset = 1'b1;
        @(negedge clock0);
        reset = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b0 || bus.wren_a !== 1'b0 || bus.address_a !== '0 || bus.data_a !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.checksum !== '0) begin
            fails++; $display("FAIL midreset_outputs got=%b%b%h%h%b%b%h exp=all zero", bus.in_ready, bus.wren_a,
                              bus.address_a, bus.data_a, bus.busy, bus.done, bus.checksum);
        end
        repeat (8) @(negedge clock0);
        tests++; if (wlog.size() - n0 != 1) begin fails++; $display("FAIL midreset_nwrites got=%0d exp=1", wlog.size() - n0); end
        if (wlog.size() > n0) begin
            tests++;
            if (wlog[n0].addr !== ea[0] || wlog[n0].data !== ed[0]) begin
                fails++; $display("FAIL midreset_first got=%h:%h exp=%h:%h", wlog[n0].addr, wlog[n0].data, ea[0], ed[0]);
            end
        end
        b     = WIDTHAD'($urandom);
        bytes = rand_bytes(NBYTES);
        model(b, 1, bytes, ea, ed);
        n0 = wlog.size();
        pulse_start(b, 13'd1);
        stream(bytes, 0, ok);
        wait_done(ok);
        tests++; if (wlog.size() - n0 != 1) begin fails++; $display("FAIL midreset_reload_n got=%0d exp=1", wlog.size() - n0); end
        if (wlog.size() > n0) begin
            tests++;
            if (wlog[n0].addr !== ea[0] || wlog[n0].data !== ed[0]) begin
                fails++; $display("FAIL midreset_reload got=%h:%h exp=%h:%h", wlog[n0].addr, wlog[n0].data, ea[0], ed[0]);
            end
        end
    endtask

    task automatic test_start_ignored;
        u8_q_t             bytes;
        addr_q_t           ea;
        data_q_t           ed;
        logic [WIDTHAD-1:0] b;
        int                n0;
        bit                ok;
        b     = WIDTHAD'($urandom);
        bytes = rand_bytes(2 * NBYTES);
        model(b, 2, bytes, ea, ed);
        n0 = wlog.size();
        pulse_start(b, 13'd2);
        stream(bytes[0:1], 0, ok);
        bus.start = 1'b1;
        bus.base  = ~b;
        bus.count = 13'd1;
        @(negedge clock0);
        bus.start = 1'b0;
        stream(bytes[2:2*NBYTES-1], 10, ok);
        wait_done(ok);
        tests++; if (!ok) begin fails++; $display("FAIL ignore_done_timeout got=0 exp=1"); end
        tests++; if (wlog.size() - n0 != 2) begin fails++; $display("FAIL ignore_nwrites got=%0d exp=2", wlog.size() - n0); end
        for (int i = 0; i < 2 && n0 + i < wlog.size(); i++) begin
            tests++;
            if (wlog[n0+i].addr !== ea[i] || wlog[n0+i].data !== ed[i]) begin
                fails++; $display("FAIL ignore_write%0d got=%h:%h exp=%h:%h", i, wlog[n0+i].addr, wlog[n0+i].data, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_random_loads;
        u8_q_t             bytes;
        addr_q_t           ea;
        data_q_t           ed;
        logic [WIDTHAD-1:0] b;
        int                n;
        int                n0;
        bit                ok;
        for (int t = 0; t < 6; t++) begin
            b     = WIDTHAD'($urandom);
            n     = int'($urandom_range(1, 4));
            bytes = rand_bytes(n * NBYTES);
            model(b, n, bytes, ea, ed);
            n0 = wlog.size();
            pulse_start(b, 13'(n));
            stream(bytes, 30, ok);
            wait_done(ok);
            tests++; if (!ok) begin fails++; $display("FAIL rand%0d_done_timeout got=0 exp=1", t); end
            tests++; if (wlog.size() - n0 != n) begin fails++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", t, wlog.size() - n0, n); end
            for (int i = 0; i < n && n0 + i < wlog.size(); i++) begin
                tests++;
                if (wlog[n0+i].addr !== ea[i] || wlog[n0+i].data !== ed[i]) begin
                    fails++; $display("FAIL rand%0d_write%0d got=%h:%h exp=%h:%h", t, i, wlog[n0+i].addr, wlog[n0+i].data, ea[i], ed[i]);
                end
            end
            tests++; if (bus.checksum !== exp_checksum(ed)) begin fails++; $display("FAIL rand%0d_checksum got=%h exp=%h", t, bus.checksum, exp_checksum(ed)); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.base     = '0;
        bus.count    = '0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_count();
        test_reset_mid_load();
        test_start_ignored();
        test_random_loads();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
